// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-input round-robin mux arbiter.
// The state enum, requester count and select width live here.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: the first set request in order start, start+1, start+2, start+3.
// When i_mask_owner is set, the last slot in that order (the current owner) is excluded.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_start,
    input  logic               i_mask_owner,
    output logic               o_found,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the farthest slot down to the nearest, so the nearest set bit is the one that remains.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_start;
        w_cand  = i_start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_start + SEL_W'(k);
            if (i_req[w_cand] && !(i_mask_owner && (k == NUM_REQ - 1))) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that drives the S1/S0 select pins of a 4:1 mux from a registered grant.
// An owner keeps the grant while it requests. It is forced off after MAX_HOLD cycles if another requester is waiting.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 S1,
    output logic                 S0,
    output logic                 busy,
    output logic [CNT_W-1:0]     owner_valid_cnt,
    output state_t               dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

    state_t             r_state, w_state;
    logic [NUM_REQ-1:0] r_gnt, w_gnt;
    logic [SEL_W-1:0]   r_sel, w_sel;
    logic               r_busy, w_busy;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [SEL_W-1:0]   r_last, w_last;

    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic               w_owner_req;
    logic               w_others;
    logic               w_release;

    // In GRANT the owner is always r_last, so one picker serves both states.
    // The search starts just past r_last. In GRANT the owner is masked, which makes it lowest priority on handoff.
    rr_pick4 u_pick (
        .i_req        (req),
        .i_start      (r_last + SEL_W'(1)),
        .i_mask_owner (r_state == GRANT),
        .o_found      (w_found),
        .o_idx        (w_idx)
    );

    assign w_owner_req = |(req & r_gnt);
    assign w_others    = |(req & ~r_gnt);
    assign w_release   = !w_owner_req || ((r_cnt == CNT_MAX) && w_others);

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_sel   = r_sel;
        w_busy  = r_busy;
        w_cnt   = r_cnt;
        w_last  = r_last;
        case (r_state)
            IDLE: begin
                w_gnt  = '0;
                w_busy = 1'b0;
                w_cnt  = '0;
                if (w_found) begin
                    w_state = GRANT;
                    w_gnt   = idx_to_onehot(w_idx);
                    w_sel   = w_idx;
                    w_busy  = 1'b1;
                    w_cnt   = CNT_W'(1);
                    w_last  = w_idx;
                end
            end
            GRANT: begin
                if (!w_release) begin
                    if (r_cnt < CNT_MAX) begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end else if (w_found) begin
                    w_gnt  = idx_to_onehot(w_idx);
                    w_sel  = w_idx;
                    w_busy = 1'b1;
                    w_cnt  = CNT_W'(1);
                    w_last = w_idx;
                end else begin
                    // r_sel is left alone so the mux select does not move while idle.
                    w_state = IDLE;
                    w_gnt   = '0;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_last  <= SEL_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_sel   <= w_sel;
            r_busy  <= w_busy;
            r_cnt   <= w_cnt;
            r_last  <= w_last;
        end
    end

    assign gnt             = r_gnt;
    assign S1              = r_sel[1];
    assign S0              = r_sel[0];
    assign busy            = r_busy;
    assign owner_valid_cnt = r_cnt;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a behavioural arbitration model feeds an expected queue,
// and a monitor compares every cycle. Directed cases are followed by randomized request traffic.
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;
    import mux4_arb_pkg::*;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;
    localparam int EXP_W    = 4 + 2 + 1 + CNT_W;
    localparam int STARVE   = 3 * MAX_HOLD + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = 4'b0000;
    logic [3:0]       gnt;
    logic             S1, S0, busy;
    logic [CNT_W-1:0] owner_valid_cnt;
    state_t           dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Model state: the owner index (-1 when idle), its tenure, the last granted index, and the mux select.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 3;
    int m_sel   = 0;

    int age[4];
    int max_age[4];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .gnt             (gnt),
        .S1              (S1),
        .S0              (S0),
        .busy            (busy),
        .owner_valid_cnt (owner_valid_cnt),
        .dbg_state       (dbg_state)
    );

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 3;
        m_sel   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int p;
        logic [3:0] others;
        if (m_owner < 0) begin
            p = pick(r, (m_last + 1) % 4);
            if (p >= 0) begin
                m_owner = p; m_cnt = 1; m_last = p; m_sel = p;
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (r[m_owner] && (m_cnt < MAX_HOLD || others == 4'b0000)) begin
                if (m_cnt < MAX_HOLD) m_cnt++;
            end else begin
                p = pick(others, (m_owner + 1) % 4);
                if (p >= 0) begin
                    m_owner = p; m_cnt = 1; m_last = p; m_sel = p;
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end
        end
    endtask

    function automatic logic [EXP_W-1:0] exp_word();
        logic [3:0] g;
        logic [1:0] s;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        s = m_sel[1:0];
        return {g, s, (m_owner >= 0), CNT_W'(m_cnt)};
    endfunction

    task automatic cycle(input logic [3:0] r);
        @(negedge clk);
        req = r;
        model_step(r);
        exp_q.push_back(exp_word());
    endtask

    task automatic hold(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(r);
    endtask

    // Asserts reset between edges. The outputs must already be at their reset values before the next clock.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, S1, S0, busy, owner_valid_cnt} != '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", {gnt, S1, S0, busy, owner_valid_cnt}, {EXP_W{1'b0}});
        end
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] a;
        int gi;
        #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) age[i] = 0;
        end else begin
            checks++;
            if (!(gnt == 4'b0000 || $onehot(gnt))) begin
                failures++;
                $display("FAIL gnt_onehot got=%b exp=onehot_or_zero", gnt);
            end
            if (busy) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
                checks++;
                if ({S1, S0} != 2'(gi)) begin
                    failures++;
                    $display("FAIL sel_matches_gnt got=%b exp=%b", {S1, S0}, 2'(gi));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !gnt[i]) age[i]++;
                else age[i] = 0;
                if (age[i] > max_age[i]) max_age[i] = age[i];
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {gnt, S1, S0, busy, owner_valid_cnt};
                checks++;
                if (a != e) begin
                    failures++;
                    $display("FAIL cycle_outputs req=%b got gnt=%b sel=%b busy=%b cnt=%0d exp gnt=%b sel=%b busy=%b cnt=%0d",
                             req, a[14:11], a[10:9], a[8], a[7:0], e[14:11], e[10:9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        int len;
        for (int i = 0; i < 4; i++) begin age[i] = 0; max_age[i] = 0; end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, S1, S0, busy, owner_valid_cnt} != '0 || dbg_state != IDLE) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {gnt, S1, S0, busy, owner_valid_cnt}, {EXP_W{1'b0}});
        end
        rst = 1'b0;
        model_reset();

        hold(4'b0001, 3);
        hold(4'b0000, 2);

        do_reset();
        hold(4'b1111, 40);
        hold(4'b0000, 1);

        do_reset();
        hold(4'b0100, 20);
        hold(4'b0000, 1);

        do_reset();
        hold(4'b0010, 2);
        hold(4'b1001, 1);
        hold(4'b0000, 2);

        do_reset();
        hold(4'b0100, 3);
        do_reset();
        hold(4'b1111, 3);
        hold(4'b0000, 1);

        for (int n = 0; n < 10000; ) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) r = r | 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            hold(r, len);
            n += len;
        end

        hold(4'b0000, 2);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (max_age[i] > STARVE) begin
                failures++;
                $display("FAIL starvation req%0d got=%0d exp<=%0d", i, max_age[i], STARVE);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter/controller for the 4:1 select mux. It shares the mux output between four requesters and drives the mux select lines S1/S0 from a registered grant. Grants are held while the owner keeps its request asserted, subject to a maximum tenure, so no requester can starve the others. It sits directly in front of the mux4x1 instance, and its S1/S0 outputs connect straight to that instance's select pins.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles before forced handoff when another requester is pending; legal range 1..255.
CNT_W, 8, tenure counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  request per mux input; bit i requests input Ii
gnt  output 4  one-hot registered grant; all-zero when idle
S1   output 1  mux select MSB (registered)
S0   output 1  mux select LSB (registered)
busy output 1  high while any grant is active
owner_valid_cnt  output CNT_W  tenure cycles elapsed for the current owner (debug/verification)

Behaviour:
- Reset (async assert; deassert is sampled on clk): gnt=0000, S1S0=00, busy=0, owner_valid_cnt=0, state=IDLE, last-granted pointer=3 (so input 0 has first priority).
- All outputs are registered; there is no combinational path from req to any output.
- Priority: round-robin starting at (last+1) mod 4 and wrapping at index 3 back to 0. Pick function: first set bit of req in order last+1, last+2, last+3, last.
- State IDLE: if req!=0 at a rising edge, the next cycle has gnt=onehot(pick), S1S0=pick, busy=1, cnt=1, last=pick, state=GRANT. Latency is 1 cycle from a sampled req to gnt. If req=0, stay in IDLE. gnt=0, and S1S0 holds its previous value so the mux select does not glitch.
- State GRANT, owner o:
  - Owner keeps req[o]=1 and either cnt<MAX_HOLD or no other req bit is set: keep the grant and increment cnt, saturating at MAX_HOLD.
  - Owner drops req[o], or cnt==MAX_HOLD while any other req bit is set: release. If other requests are pending, hand off directly (next cycle gnt=onehot of pick among those other requests, with the search starting at o+1; cnt=1; last updated). This is a back-to-back switch with no idle cycle. Otherwise go to IDLE with gnt=0, busy=0, cnt=0.
  - A dropped req[o] that is re-asserted in the same cycle the release is evaluated is treated as dropped. The owner is then lowest priority for this arbitration.
- Simultaneous events: all four requests asserted continuously produce grants 0,1,2,3,0,…, each held exactly MAX_HOLD cycles.
- A single requester is never preempted. cnt saturates at MAX_HOLD.
- gnt is always one-hot or zero. Whenever busy=1, S1S0 equals the index of the set gnt bit.
- Reset mid-grant: outputs go immediately (asynchronously) to their reset values, and the pointer returns to 3.

Decomposition:
- Package mux4_arb_pkg holds:
  - State enum {IDLE, GRANT}.
  - Constant NUM_REQ=4 and SEL_W=2.
  - Function idx_to_onehot.
- Sub-module rr_pick4 is combinational. Inputs are req[3:0], start[1:0] and mask_owner. Outputs are found and idx[1:0]. It is instantiated once in mux4_rr_arbiter.

Test Plan:
- Reset then req=0001 held 3 cycles -> gnt=0001, S1S0=00 from cycle 1, busy=1; req drops -> gnt=0000 next cycle, S1S0 stays 00.
- From reset, req=1111 held 40 cycles, MAX_HOLD=8 -> grants 0001,0010,0100,1000,0001 each exactly 8 cycles; S1S0 sequence 00,01,10,11,00; no idle gaps.
- Owner 2 granted, req=0100 alone held 20 cycles -> gnt stays 0100 all 20 cycles, owner_valid_cnt saturates at 8.
- Owner 1 drops req while req=1001 pending -> next cycle gnt=1000 (index 3 before 0 in order after 1), S1S0=11.
- Reset asserted asynchronously mid-grant (gnt=0100) -> gnt=0000, S1S0=00, busy=0 before the next clk edge; after release, req=1111 -> first grant 0001.
- Random req stress, 10k cycles -> gnt one-hot or zero; S1S0 matches the gnt index when busy; every pending requester is granted within 3*MAX_HOLD+3 cycles.
